// File: rtl/rtn_xbar_arb.sv
`default_nettype none
// ============================================================================
// Module   : rtn_xbar_arb
// Purpose  : Per-channel round-robin arbiter and handshake sequencer for the
//            response-return crossbar (4 memory banks -> 3 upstream channels).
//            Each channel picks one requesting bank, holds that grant until
//            the channel accepts, then pops the bank. A head that targets the
//            illegal channel id 3 is drained immediately and flagged.
// Ports    : clk          - clock, all state on rising edge
//            rst          - synchronous reset, active-high
//            bank_vld     - bank b has a head response
//            bank_ch_id   - [2b+1:2b] destination channel of bank b head
//            bank_rdy     - pop pulse to bank b (head consumed this cycle)
//            ch_vld       - channel c response valid
//            ch_rdy       - channel c accepts
//            ch_bank_1hot - [4c+3:4c] one-hot granted bank for channel c
//            ch_bank_id   - [2c+1:2c] binary granted bank for channel c
//            err_bad_ch   - sticky illegal-channel-id flag
// Revision : 1.0 - initial release
// ============================================================================
module rtn_xbar_arb #(
  parameter int NB = 4,
  parameter int NC = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NB-1:0]      bank_vld,
  input  logic [2*NB-1:0]    bank_ch_id,
  output logic [NB-1:0]      bank_rdy,
  output logic [NC-1:0]      ch_vld,
  input  logic [NC-1:0]      ch_rdy,
  output logic [NB*NC-1:0]   ch_bank_1hot,
  output logic [2*NC-1:0]    ch_bank_id,
  output logic               err_bad_ch
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // First set bit of req scanning start, start+1, ... (mod 4). The loop runs
  // from the farthest position inward so the nearest request overwrites.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [3:0] win;
    logic [1:0] idx;
    win = 4'b0000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) win = 4'b0001 << idx;
    end
    return win;
  endfunction

  function automatic logic [1:0] enc4(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  logic [NB-1:0] drain;
  logic [NB-1:0] pop [NC];
  logic [NB-1:0] rdy_any;

  // Heads addressed to channel id 3 have no consumer; drop them on sight.
  always_comb begin
    drain = '0;
    for (int b = 0; b < NB; b++) begin
      drain[b] = bank_vld[b] & (bank_ch_id[2*b +: 2] == 2'd3);
    end
  end

  for (genvar c = 0; c < NC; c++) begin : g_ch
    logic [0:0] state;
    logic [3:0] grant;
    logic [1:0] rr;
    logic [3:0] req;
    logic [3:0] win_idle;
    logic [3:0] win_next;
    logic       hs;

    always_comb begin
      req = '0;
      for (int b = 0; b < NB; b++) begin
        req[b] = bank_vld[b] & (bank_ch_id[2*b +: 2] == 2'(c));
      end
    end

    // On a handshake the popped bank is masked: its next head only becomes
    // visible after the pop, so it cannot be re-granted in the same edge.
    assign win_idle = rr_pick(req, rr);
    assign win_next = rr_pick(req & ~grant, enc4(grant) + 2'd1);
    assign hs       = (state == S_BUSY) & ch_rdy[c];

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= S_IDLE;
        grant <= 4'b0000;
        rr    <= 2'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req != 4'b0000) begin
              grant <= win_idle;
              state <= S_BUSY;
            end else begin
              grant <= 4'b0000;
            end
          end
          S_BUSY: begin
            if (ch_rdy[c]) begin
              rr    <= enc4(grant) + 2'd1;
              grant <= win_next;
              state <= (win_next != 4'b0000) ? S_BUSY : S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
            grant <= 4'b0000;
          end
        endcase
      end
    end

    assign ch_vld[c]              = (state == S_BUSY);
    assign ch_bank_1hot[4*c +: 4] = grant;
    assign ch_bank_id[2*c +: 2]   = enc4(grant);
    assign pop[c]                 = grant & {4{hs}};
  end

  // Suppressed during rst so an abandoned grant or a drain never pops a bank.
  always_comb begin
    rdy_any = drain;
    for (int c = 0; c < NC; c++) begin
      rdy_any = rdy_any | pop[c];
    end
    bank_rdy = rst ? '0 : rdy_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_bad_ch <= 1'b0;
    end else if (drain != '0) begin
      err_bad_ch <= 1'b1;
    end
  end

endmodule
`default_nettype wire
